// File: rtl/j1_io_pkg.sv
// j1_io_pkg: register map, status bit positions and FSM states shared by J1 I/O responders
package j1_io_pkg;
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DIV    = 3'd2;
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_IDLE  = 2;
  localparam int ST_RX_OVF   = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_FERR     = 5;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  // Bit-period reload value; divisors 0 and 1 both give a one-clock bit
  function automatic logic [15:0] bit_reload(input logic [15:0] div);
    return (div < 16'd2) ? 16'd0 : div - 16'd1;
  endfunction
endpackage

// File: rtl/io_fifo.sv
// io_fifo: 8-bit synchronous FIFO with show-ahead head; a push while full is accepted only alongside a pop
module io_fifo #(
  parameter int LOG2 = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);
  logic [7:0] mem_q [2**LOG2];
  logic [LOG2-1:0] wr_q, rd_q;
  logic [LOG2:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q[LOG2];
  assign do_pop  = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);
  assign head_o  = mem_q[rd_q];
  // Storage needs no reset: the occupancy count hides stale entries
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  // Pointers and occupancy
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + LOG2'(1);
      if (do_pop) rd_q <= rd_q + LOG2'(1);
      cnt_q <= cnt_q + (LOG2+1)'(do_push) - (LOG2+1)'(do_pop);
    end
endmodule

// File: rtl/j1_uart_io.sv
// j1_uart_io: memory-mapped 8N1 UART responder on the J1 I/O bus
module j1_uart_io
  import j1_io_pkg::*;
#(
  parameter logic [15:0] BASE        = 16'h1000,
  parameter int          FIFO_LOG2   = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd417
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] dout,
  output logic [15:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx
);
  logic sel, wr_data, wr_stat, wr_div, rx_pop, rx_s, unused_ok;
  logic [2:0] rsel;
  logic [15:0] div_q, status;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic tx_free, tx_load, tx_pop, tx_push, rx_push, ferr_set;
  logic rx_ovf_q, tx_ovf_q, ferr_q;
  logic [1:0] sync_q;
  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_q, tx_d;
  assign unused_ok = mem_addr[0];
  assign sel       = mem_addr[15:4] == BASE[15:4];
  assign rsel      = mem_addr[3:1];
  assign wr_data   = sel & io_wr & (rsel == REG_DATA);
  assign wr_stat   = sel & io_wr & (rsel == REG_STATUS);
  assign wr_div    = sel & io_wr & (rsel == REG_DIV);
  assign rx_pop    = sel & io_rd & !io_wr & (rsel == REG_DATA);
  assign rx_s      = sync_q[1];
  assign uart_tx   = tx_q;
  // The shifter is free when idle or in the last clock of a stop bit; a write into an
  // empty FIFO at that moment bypasses it so the start bit follows the write directly
  assign tx_free = (tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & (tx_cnt_q == 16'd0));
  assign tx_load = tx_free & (!tx_empty | wr_data);
  assign tx_pop  = tx_free & !tx_empty;
  assign tx_push = wr_data & !(tx_free & tx_empty);
  io_fifo #(.LOG2(FIFO_LOG2)) u_tx_fifo (
    .clk(clk), .resetq(resetq), .push_i(tx_push), .din_i(dout[7:0]), .pop_i(tx_pop),
    .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );
  io_fifo #(.LOG2(FIFO_LOG2)) u_rx_fifo (
    .clk(clk), .resetq(resetq), .push_i(rx_push), .din_i(rx_sh_q), .pop_i(rx_pop),
    .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );
  // Status word and read mux; zero when the window is not selected
  always_comb begin
    status = '0;
    status[ST_RX_AVAIL] = !rx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_IDLE]  = tx_empty & (tx_state_q == TX_IDLE);
    status[ST_RX_OVF]   = rx_ovf_q;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_FERR]     = ferr_q;
    io_din = !sel ? 16'h0 :
             (rsel == REG_DATA) ? {8'h0, rx_empty ? 8'h0 : rx_head} :
             (rsel == REG_STATUS) ? status :
             (rsel == REG_DIV) ? div_q : 16'h0;
  end
  // TX next state: start, 8 data bits LSB first, stop, each one bit period long
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q - 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    if (tx_load) begin
      tx_state_d = TX_START;
      tx_cnt_d   = bit_reload(div_q);
      tx_sh_d    = tx_empty ? dout[7:0] : tx_head;
    end else if (tx_state_q == TX_IDLE) begin
      tx_cnt_d = tx_cnt_q;
    end else if (tx_cnt_q == 16'd0) begin
      tx_cnt_d   = bit_reload(div_q);
      tx_bit_d   = (tx_state_q == TX_DATA) ? tx_bit_q + 3'd1 : 3'd0;
      tx_sh_d    = (tx_state_q == TX_DATA) ? tx_sh_q >> 1 : tx_sh_q;
      tx_state_d = (tx_state_q == TX_START) ? TX_DATA :
                   (tx_state_q == TX_STOP) ? TX_IDLE :
                   (tx_bit_q == 3'd7) ? TX_STOP : TX_DATA;
    end
    tx_d = (tx_state_d == TX_START) ? 1'b0 : (tx_state_d == TX_DATA) ? tx_sh_d[0] : 1'b1;
  end
  // RX next state: confirm the start bit at half a period, then sample once per period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q - 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      rx_cnt_d   = div_q >> 1;
      rx_state_d = rx_s ? RX_IDLE : RX_START;
    end else if (rx_cnt_q == 16'd0) begin
      rx_cnt_d   = bit_reload(div_q);
      rx_bit_d   = (rx_state_q == RX_DATA) ? rx_bit_q + 3'd1 : 3'd0;
      rx_sh_d    = (rx_state_q == RX_DATA) ? {rx_s, rx_sh_q[7:1]} : rx_sh_q;
      rx_state_d = (rx_state_q == RX_START) ? (rx_s ? RX_IDLE : RX_DATA) :
                   (rx_state_q == RX_STOP) ? RX_IDLE :
                   (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
      rx_push    = (rx_state_q == RX_STOP) & rx_s;
      ferr_set   = (rx_state_q == RX_STOP) & !rx_s;
    end
  end
  // Shifter state; reset drives the line idle-high at once
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  // Divisor, sticky flags (a new event beats a same-cycle clear) and the rx synchroniser
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      div_q    <= DEFAULT_DIV;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      ferr_q   <= 1'b0;
      sync_q   <= 2'b11;
    end else begin
      div_q    <= wr_div ? dout : div_q;
      rx_ovf_q <= (rx_push & rx_full & !rx_pop) | (rx_ovf_q & !(wr_stat & dout[ST_RX_OVF]));
      tx_ovf_q <= (tx_push & tx_full & !tx_pop) | (tx_ovf_q & !(wr_stat & dout[ST_TX_OVF]));
      ferr_q   <= ferr_set | (ferr_q & !(wr_stat & dout[ST_FERR]));
      sync_q   <= {sync_q[0], uart_rx};
    end
endmodule

// File: tb/tb_j1_uart_io.sv
// tb_j1_uart_io: register vectors, serial frame scoreboard and multi-cycle corner cases for j1_uart_io
module tb_j1_uart_io;
  localparam logic [15:0] A_DATA = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h1002;
  localparam logic [15:0] A_DIV  = 16'h1004;
  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[16];
  logic clk = 1'b0, resetq = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
  logic loop = 1'b0, rx_drv = 1'b1, mon_en = 1'b1;
  logic [15:0] mem_addr = 16'h0, dout = 16'h0, io_din, rdata;
  logic uart_rx, uart_tx;
  logic [7:0] mon_b;
  logic [9:0] fr;
  int n_tests = 0, n_fail = 0, cyc;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  assign uart_rx = loop ? uart_tx : rx_drv;
  j1_uart_io dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .mem_addr(mem_addr),
    .dout(dout), .io_din(io_din), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_addr = a;
    dout = d;
    io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask
  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    mem_addr = a;
    io_rd = 1'b1;
    #1 d = io_din;
    @(negedge clk);
    io_rd = 1'b0;
  endtask
  task automatic tx_byte(input logic [7:0] b);
    exp_q.push_back(b);
    bus_wr(A_DATA, {8'h0, b});
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = f[i];
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    rx_drv = 1'b1;
  endtask
  // Peek STATUS (no strobe, so no side effects) until bit b equals v or the budget runs out
  task automatic wait_st(input int b, input logic v, input int budget, output int c);
    mem_addr = A_STAT;
    #1 c = 0;
    while (io_din[b] !== v && c < budget) begin
      @(negedge clk);
      #1 c++;
    end
  endtask
  // Serial monitor: decodes frames at mid-bit (DIV=4) and checks them against the queue
  initial forever begin
    @(negedge clk);
    if (mon_en && resetq && uart_tx === 1'b0) begin
      @(negedge clk);
      chk("tx_start_bit", {15'h0, uart_tx}, 16'h0);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        mon_b[i] = uart_tx;
      end
      repeat (4) @(negedge clk);
      chk("tx_stop_bit", {15'h0, uart_tx}, 16'h1);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_frame: got %h, no byte expected", mon_b);
      end else chk("tx_frame", {8'h0, mon_b}, {8'h0, exp_q.pop_front()});
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{1'b0, 16'h1002, 16'h0000, 16'h0004};
    vt[1]  = '{1'b0, 16'h1003, 16'h0000, 16'h0004};
    vt[2]  = '{1'b0, 16'h1004, 16'h0000, 16'd417};
    vt[3]  = '{1'b0, 16'h1000, 16'h0000, 16'h0000};
    vt[4]  = '{1'b0, 16'h1006, 16'h0000, 16'h0000};
    vt[5]  = '{1'b0, 16'h100C, 16'h0000, 16'h0000};
    vt[6]  = '{1'b0, 16'h2002, 16'h0000, 16'h0000};
    vt[7]  = '{1'b0, 16'h0004, 16'h0000, 16'h0000};
    vt[8]  = '{1'b1, 16'h1004, 16'h1234, 16'h0000};
    vt[9]  = '{1'b0, 16'h1004, 16'h0000, 16'h1234};
    vt[10] = '{1'b1, 16'h1006, 16'hFFFF, 16'h0000};
    vt[11] = '{1'b0, 16'h1006, 16'h0000, 16'h0000};
    vt[12] = '{1'b1, 16'h1002, 16'hFFFF, 16'h0000};
    vt[13] = '{1'b0, 16'h1002, 16'h0000, 16'h0004};
    vt[14] = '{1'b1, 16'h1004, 16'h0004, 16'h0000};
    vt[15] = '{1'b0, 16'h1004, 16'h0000, 16'h0004};
    repeat (3) @(negedge clk);
    chk("reset_tx_high", {15'h0, uart_tx}, 16'h1);
    resetq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (vt[i].we) bus_wr(vt[i].a, vt[i].d);
      else begin
        bus_rd(vt[i].a, rdata);
        chk($sformatf("vec%0d_rd_%h", i, vt[i].a), rdata, vt[i].exp);
      end
    end
    // Exact TX waveform for 0x41 at four clocks per bit
    fr = {1'b1, 8'h41, 1'b0};
    tx_byte(8'h41);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("tx41_cycle%0d", k), {15'h0, uart_tx}, {15'h0, fr[k/4]});
      @(negedge clk);
    end
    wait_st(2, 1'b1, 50, cyc);
    chk("tx41_idle", {15'h0, io_din[2]}, 16'h1);
    // Loopback
    loop = 1'b1;
    tx_byte(8'h55);
    wait_st(0, 1'b1, 60, cyc);
    chk("loop_rx_avail", {15'h0, io_din[0]}, 16'h1);
    chk("loop_latency_le46", 16'(cyc <= 46), 16'h1);
    bus_rd(A_DATA, rdata);
    chk("loop_data", rdata, 16'h0055);
    bus_rd(A_STAT, rdata);
    chk("loop_status_after_pop", rdata, 16'h0004);
    loop = 1'b0;
    // TX overflow: one byte on the line, then 17 more writes
    tx_byte(8'hA0);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      bus_wr(A_DATA, 16'(i));
    end
    bus_rd(A_STAT, rdata);
    chk("ovf_status", rdata, 16'h0012);
    bus_wr(A_STAT, 16'h0010);
    bus_rd(A_STAT, rdata);
    chk("ovf_cleared", rdata & 16'h0010, 16'h0000);
    wait_st(2, 1'b1, 720, cyc);
    chk("ovf_drained_idle", {15'h0, io_din[2]}, 16'h1);
    repeat (4) @(negedge clk);
    chk("ovf_all_frames_seen", 16'(exp_q.size()), 16'h0);
    // One-clock glitch is rejected
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    bus_rd(A_STAT, rdata);
    chk("glitch_no_byte", rdata, 16'h0004);
    // Framing error
    send_rx(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    bus_rd(A_STAT, rdata);
    chk("ferr_set", rdata, 16'h0024);
    bus_wr(A_STAT, 16'h0020);
    bus_rd(A_STAT, rdata);
    chk("ferr_cleared", rdata, 16'h0004);
    // Good frame from the line
    send_rx(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    bus_rd(A_STAT, rdata);
    chk("rx_a5_status", rdata, 16'h0005);
    bus_rd(A_DATA, rdata);
    chk("rx_a5_data", rdata, 16'h00A5);
    // Empty RX read has no effect
    bus_rd(A_DATA, rdata);
    chk("rx_empty_read", rdata, 16'h0000);
    bus_rd(A_STAT, rdata);
    chk("rx_empty_read_status", rdata, 16'h0004);
    // Simultaneous read and write on DATA: push only, no pop
    send_rx(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    @(negedge clk);
    mem_addr = A_DATA;
    dout = 16'h0077;
    io_rd = 1'b1;
    io_wr = 1'b1;
    exp_q.push_back(8'h77);
    @(negedge clk);
    io_rd = 1'b0;
    io_wr = 1'b0;
    bus_rd(A_STAT, rdata);
    chk("rdwr_status", rdata, 16'h0001);
    bus_rd(A_DATA, rdata);
    chk("rdwr_rx_kept", rdata, 16'h005A);
    wait_st(2, 1'b1, 60, cyc);
    chk("rdwr_tx_idle", {15'h0, io_din[2]}, 16'h1);
    repeat (4) @(negedge clk);
    chk("rdwr_frame_seen", 16'(exp_q.size()), 16'h0);
    // Reset in the middle of a frame
    mon_en = 1'b0;
    bus_wr(A_DATA, 16'h0099);
    repeat (9) @(negedge clk);
    #1 chk("midtx_line_low", {15'h0, uart_tx}, 16'h0);
    resetq = 1'b0;
    #1 chk("midtx_reset_tx_high", {15'h0, uart_tx}, 16'h1);
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    bus_rd(A_STAT, rdata);
    chk("midtx_status", rdata, 16'h0004);
    bus_rd(A_DIV, rdata);
    chk("midtx_div", rdata, 16'd417);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
